uart_tx_fifo: RTL and testbench

Byte-wide buffered front end for the UART transmitter. It accepts bytes from the system side over a valid/ready handshake and stores them in a FIFO. It drains them one at a time into the transmitter's `uart_tx_en` / `uart_tx_data` / `uart_tx_busy` interface, so bursty producers never have to watch the line rate. It sits directly upstream of the transmitter, in the same clock domain.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_tx_fifo.sv | 87 ++++++++
 tb/tb_uart_tx_fifo.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the buffered UART transmit path.
// The drain state encoding is fixed so waveforms read the same across builds.
package uart_pkg;

  localparam int DEFAULT_PAYLOAD_BITS = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } uart_fifo_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with a level counter and a combinational head read.
// Flush wins over push and pop; full and empty are decoded from the registered level.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int LVL_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        level <= level + 1'b1;
      end else if (do_pop && !do_push) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered front end for the UART transmitter: queues bytes from a valid/ready
// producer and hands them to the transmitter one frame at a time.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic                    tx_en,
  output logic [PAYLOAD_BITS-1:0] tx_data,
  input  logic                    tx_busy,
  output logic [LVL_W-1:0]        level,
  output logic                    full,
  output logic                    empty
);

  uart_fifo_state_t        state;
  logic [PAYLOAD_BITS-1:0] head;
  logic                    push;
  logic                    pop;

  // Readiness depends only on the registered level, never on a same-cycle pop.
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (state == IDLE) && !empty && !tx_busy && !flush;

  sync_fifo #(
    .WIDTH(PAYLOAD_BITS),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .wdata(in_data),
    .rdata(head),
    .level(level),
    .full (full),
    .empty(empty)
  );

  // A byte already issued runs to completion even across a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx_en   <= 1'b0;
      tx_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state   <= ISSUE;
            tx_en   <= 1'b1;
            tx_data <= head;
          end
        end
        ISSUE: begin
          state <= WAIT_BUSY;
          tx_en <= 1'b0;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          tx_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, and a randomized phase.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic             tx_en;
  logic [7:0]       tx_data;
  logic             tx_busy = 1'b0;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             empty;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  logic hold_busy;
  int   frame_len;
  int   busy_cnt = 0;

  logic [7:0] q[$];
  logic [7:0] sent[$];
  bit         m_tx_en = 1'b0;
  logic [7:0] m_tx_data = 8'h00;
  bit         in_flight = 1'b0;
  bit         saw_busy = 1'b0;
  bit         do_push;
  bit         do_pop;
  bit         was_en;

  uart_tx_fifo #(.DEPTH(DEPTH), .PAYLOAD_BITS(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .flush   (flush),
    .tx_en   (tx_en),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  // Transmitter stand-in: busy from the edge after it samples tx_en, for frame_len cycles.
  always @(posedge clk) begin
    if (hold_busy) begin
      tx_busy <= 1'b1;
    end else if (tx_en === 1'b1) begin
      tx_busy  <= 1'b1;
      busy_cnt <= frame_len;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      tx_busy  <= (busy_cnt > 1);
    end else begin
      tx_busy <= 1'b0;
    end
  end

  // Reference: a byte queue plus "one frame in flight until busy has come and gone".
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_tx_en   = 1'b0;
      m_tx_data = 8'h00;
      in_flight = 1'b0;
      saw_busy  = 1'b0;
    end else begin
      do_push = in_valid && (q.size() < DEPTH) && !flush;
      do_pop  = !in_flight && (q.size() > 0) && !tx_busy && !flush;
      was_en  = m_tx_en;
      m_tx_en = do_pop;
      if (flush) q.delete();
      if (do_pop) begin
        m_tx_data = q.pop_front();
        in_flight = 1'b1;
        saw_busy  = 1'b0;
      end else if (in_flight && !was_en) begin
        if (!saw_busy) saw_busy = tx_busy;
        else if (!tx_busy) in_flight = 1'b0;
      end
      if (do_push) q.push_back(in_data);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      checkOutput("level", 32'(level), q.size());
      checkOutput("full", 32'(full), 32'(q.size() == DEPTH));
      checkOutput("empty", 32'(empty), 32'(q.size() == 0));
      checkOutput("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
      checkOutput("tx_en", 32'(tx_en), 32'(m_tx_en));
      checkOutput("tx_data", 32'(tx_data), 32'(m_tx_data));
    end
  end

  always @(posedge clk) begin
    #1;
    if (tx_en === 1'b1) sent.push_back(tx_data);
  end

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic f);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    flush    = f;
  endtask

  task automatic pushByte(input logic [7:0] d);
    int n;
    n = 0;
    applyStimulus(1'b1, d, 1'b0);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("push_accepted", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    int base;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0;
    hold_busy = 1'b0; frame_len = 20;
    @(negedge clk);
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_tx_en", 32'(tx_en), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("idle_no_tx", sent.size(), 32'd0);

    $display("[TB] single byte latency");
    pushByte(8'hA5);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("a5_level_after_write", 32'(level), 32'd1);
    checkOutput("a5_tx_en_k", 32'(tx_en), 32'd0);
    @(negedge clk);
    checkOutput("a5_tx_en_k1", 32'(tx_en), 32'd1);
    checkOutput("a5_tx_data", 32'(tx_data), 32'hA5);
    @(negedge clk);
    checkOutput("a5_tx_en_k2", 32'(tx_en), 32'd0);
    repeat (30) @(negedge clk);
    checkOutput("a5_level_drained", 32'(level), 32'd0);
    checkOutput("a5_single_strobe", sent.size(), 32'd1);

    $display("[TB] burst of 17 against a busy transmitter");
    sent.delete();
    frame_len = 3;
    hold_busy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) pushByte(8'(i));
    applyStimulus(1'b1, 8'h10, 1'b0);
    checkOutput("burst_full", 32'(full), 32'd1);
    checkOutput("burst_in_ready", 32'(in_ready), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("burst_held_level", 32'(level), 32'd16);
    hold_busy = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("burst_17th_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    n = 0;
    while (sent.size() < 17 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    checkOutput("burst_count", sent.size(), 32'd17);
    for (int i = 0; i < 17 && i < sent.size(); i++) checkOutput("burst_order", 32'(sent[i]), i);

    $display("[TB] simultaneous push/pop and pop at full");
    hold_busy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) pushByte(8'h40 + 8'(i));
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("pp_level5", 32'(level), 32'd5);
    hold_busy = 1'b0;
    applyStimulus(1'b1, 8'h45, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("pp_level_held", 32'(level), 32'd5);
    checkOutput("pp_tx_en", 32'(tx_en), 32'd1);
    checkOutput("pp_tx_data", 32'(tx_data), 32'h40);
    hold_busy = 1'b1;
    for (int i = 0; i < 11; i++) pushByte(8'h50 + 8'(i));
    applyStimulus(1'b1, 8'hEE, 1'b0);
    checkOutput("pf_full", 32'(full), 32'd1);
    hold_busy = 1'b0;
    n = 0;
    while (tx_en !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    checkOutput("pf_pop_seen", 32'(tx_en), 32'd1);
    checkOutput("pf_no_write", 32'(level), 32'd15);
    repeat (200) @(negedge clk);
    checkOutput("pf_drained", 32'(level), 32'd0);

    $display("[TB] flush during an in-flight frame");
    sent.delete();
    frame_len = 20;
    pushByte(8'h3C);
    for (int i = 0; i < 8; i++) pushByte(8'h80 + 8'(i));
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("fl_level8", 32'(level), 32'd8);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("fl_level0", 32'(level), 32'd0);
    checkOutput("fl_empty", 32'(empty), 32'd1);
    repeat (50) @(negedge clk);
    checkOutput("fl_count", sent.size(), 32'd1);
    if (sent.size() > 0) checkOutput("fl_byte", 32'(sent[0]), 32'h3C);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 600; c++) begin
      frame_len = $urandom_range(1, 4);
      applyStimulus($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 3);
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (200) @(negedge clk);
    checkOutput("rand_drained", 32'(level), 32'd0);

    $display("[TB] reset during WAIT_BUSY");
    frame_len = 20;
    pushByte(8'h5A);
    applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("rb_tx_en", 32'(tx_en), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    hold_busy = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    base = sent.size();
    checkOutput("rb_tx_en_after_reset", 32'(tx_en), 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("rb_no_tx_held", sent.size(), base);
    hold_busy = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("rb_no_tx_idle", sent.size(), base);
    pushByte(8'h77);
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("rb_new_count", sent.size(), base + 1);
    if (sent.size() > 0) checkOutput("rb_new_byte", 32'(sent[$]), 32'h77);
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
